// File: rtl/decode_interlock_ctrl_if.sv
// Signal bundle between the decode datapath (master) and decode_interlock_ctrl (slave).
interface decode_interlock_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             de_v;
  logic [31:0]      de_ir;
  logic             mem_stall;
  logic             wb_v;
  logic             wb_ld_done;
  logic [4:0]       wb_drid;
  logic             br_resolved;
  logic             br_taken;
  logic             de_stall;
  logic             exe_v_in;
  logic             fe_flush;
  logic             br_to;
  logic [1:0]       state;
  logic [CNT_W-1:0] ldu_cycles;
  logic [CNT_W-1:0] brw_cycles;

  modport master (
    output de_v, de_ir, mem_stall, wb_v, wb_ld_done, wb_drid, br_resolved, br_taken,
    input  de_stall, exe_v_in, fe_flush, br_to, state, ldu_cycles, brw_cycles
  );

  modport slave (
    input  de_v, de_ir, mem_stall, wb_v, wb_ld_done, wb_drid, br_resolved, br_taken,
    output de_stall, exe_v_in, fe_flush, br_to, state, ldu_cycles, brw_cycles
  );
endinterface

// File: rtl/decode_interlock_ctrl.sv
// Decode-stage interlock: load-use scoreboard plus branch/JALR wait FSM driving stall/bubble/flush.
// Optional performance counters are built when DECODE_INTERLOCK_PERF_EN is defined.
module decode_interlock_ctrl #(
  parameter int BR_TIMEOUT = 16,
  parameter int CNT_W      = 32
) (
  input logic                    clk,
  input logic                    reset,
  decode_interlock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(BR_TIMEOUT - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPI    = 7'b0010011;
  localparam logic [6:0] OPC_OPI32  = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic f_use_rs1(input logic [6:0] opc, input logic f3_msb);
    logic res;
    case (opc)
      OPC_OP, OPC_OP32, OPC_OPI, OPC_OPI32,
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: res = 1'b1;
      OPC_SYSTEM:                                res = ~f3_msb; // CSR immediate forms carry uimm, not rs1
      default:                                   res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic f_use_rs2(input logic [6:0] opc);
    logic res;
    case (opc)
      OPC_OP, OPC_OP32, OPC_STORE, OPC_BRANCH: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic f_is_cf(input logic [6:0] opc);
    logic res;
    case (opc)
      OPC_BRANCH, OPC_JALR: res = 1'b1;
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

  state_e      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [31:0] pend_r, pend_nxt_s;
  logic        fe_flush_r, br_to_r, br_to_nxt_s;

  logic [6:0]  opc_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic        use_rs1_s, use_rs2_s, is_ld_s, is_cf_s;
  logic        hazard_s, issue_s;
  logic        unused_ir_s;

  assign opc_s       = bus.de_ir[6:0];
  assign rd_s        = bus.de_ir[11:7];
  assign rs1_s       = bus.de_ir[19:15];
  assign rs2_s       = bus.de_ir[24:20];
  assign unused_ir_s = ^{bus.de_ir[31:25], bus.de_ir[13:12]};

  assign use_rs1_s = f_use_rs1(opc_s, bus.de_ir[14]);
  assign use_rs2_s = f_use_rs2(opc_s);
  assign is_ld_s   = (opc_s == OPC_LOAD) && (rd_s != 5'd0);
  assign is_cf_s   = f_is_cf(opc_s);

  assign hazard_s = bus.de_v &
                    ((use_rs1_s & (rs1_s != 5'd0) & pend_r[rs1_s]) |
                     (use_rs2_s & (rs2_s != 5'd0) & pend_r[rs2_s]));
  assign issue_s  = bus.de_v & (state_r == ST_RUN) & ~hazard_s & ~bus.mem_stall;

  assign bus.exe_v_in = issue_s;
  assign bus.de_stall = bus.mem_stall | hazard_s | (state_r != ST_RUN);
  assign bus.state    = state_r;
  assign bus.fe_flush = fe_flush_r;
  assign bus.br_to    = br_to_r;

  // Scoreboard next value: WB clears first so a same-index load issue wins.
  always_comb begin
    pend_nxt_s = pend_r;
    if (bus.wb_v && bus.wb_ld_done) begin
      pend_nxt_s[bus.wb_drid] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (issue_s && is_ld_s) begin
      pend_nxt_s[rd_s] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Control-flow FSM next state, wait counter and timeout pulse.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    br_to_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (issue_s && is_cf_s) begin
          state_nxt_s = ST_BR_WAIT;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_BR_WAIT: begin
        cnt_nxt_s = cnt_r + 8'd1;
        if (bus.br_resolved) begin
          state_nxt_s = bus.br_taken ? ST_FLUSH : ST_RUN;
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = ST_RUN;
          br_to_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_BR_WAIT;
        end
      end
      ST_FLUSH: state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // State, scoreboard and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      cnt_r      <= 8'd0;
      pend_r     <= 32'd0;
      fe_flush_r <= 1'b0;
      br_to_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      pend_r     <= pend_nxt_s;
      fe_flush_r <= (state_nxt_s == ST_FLUSH);
      br_to_r    <= br_to_nxt_s;
    end
  end

`ifdef DECODE_INTERLOCK_PERF_EN
  logic [CNT_W-1:0] ldu_r, brw_r;

  // Saturating stall-cycle counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldu_r <= {CNT_W{1'b0}};
      brw_r <= {CNT_W{1'b0}};
    end else begin
      if (hazard_s && (state_r == ST_RUN) && (ldu_r != {CNT_W{1'b1}})) begin
        ldu_r <= ldu_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ldu_r <= ldu_r;
      end
      if ((state_r == ST_BR_WAIT) && (brw_r != {CNT_W{1'b1}})) begin
        brw_r <= brw_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        brw_r <= brw_r;
      end
    end
  end

  assign bus.ldu_cycles = ldu_r;
  assign bus.brw_cycles = brw_r;
`else
  assign bus.ldu_cycles = {CNT_W{1'b0}};
  assign bus.brw_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decode_interlock_ctrl.sv
// Self-checking bench for decode_interlock_ctrl: directed scenarios then random traffic vs a reference model.
module tb_decode_interlock_ctrl;
  localparam int TO_CYC = 16;
  localparam int CW     = 32;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_CSR  = 7'b1110011;

  logic clk = 1'b0;
  logic reset;

  decode_interlock_ctrl_if #(.CNT_W(CW)) bus ();
  decode_interlock_ctrl #(.BR_TIMEOUT(TO_CYC), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: pending loads, control mode (0 run, 1 waiting, 2 flushing)
  bit [31:0]   m_pend;
  int          m_mode;
  int          m_spent;
  bit          m_to;
  longint      m_ldu, m_brw;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [6:0] op, int rd, int rs1, int rs2, logic [2:0] f3);
    return {7'd0, 5'(rs2), 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic bit t_rs1(logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return (op inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011,
                       7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111}) ||
           (op == 7'b1110011 && ir[14] == 1'b0);
  endfunction

  function automatic bit t_rs2(logic [31:0] ir);
    return ir[6:0] inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit t_hazard(bit v, logic [31:0] ir);
    int r1, r2;
    r1 = int'(ir[19:15]);
    r2 = int'(ir[24:20]);
    return v && ((t_rs1(ir) && r1 != 0 && m_pend[r1]) || (t_rs2(ir) && r2 != 0 && m_pend[r2]));
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mode = 0; m_spent = 0; m_to = 0; m_ldu = 0; m_brw = 0;
  endtask

  task automatic idle();
    bus.de_v = 1'b0; bus.de_ir = 32'd0; bus.mem_stall = 1'b0;
    bus.wb_v = 1'b0; bus.wb_ld_done = 1'b0; bus.wb_drid = 5'd0;
    bus.br_resolved = 1'b0; bus.br_taken = 1'b0;
  endtask

  // Check outputs against the model mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit hz, iss;
    int rd;
    @(negedge clk);
    hz  = t_hazard(bus.de_v, bus.de_ir);
    iss = bus.de_v && m_mode == 0 && !hz && !bus.mem_stall;
    check("exe_v_in", 64'(bus.exe_v_in), 64'(iss));
    check("de_stall", 64'(bus.de_stall), 64'(bus.mem_stall || hz || m_mode != 0));
    check("fe_flush", 64'(bus.fe_flush), 64'(m_mode == 2));
    check("br_to", 64'(bus.br_to), 64'(m_to));
    check("state", 64'(bus.state), 64'(m_mode));
`ifdef DECODE_INTERLOCK_PERF_EN
    check("ldu_cycles", 64'(bus.ldu_cycles), 64'(m_ldu));
    check("brw_cycles", 64'(bus.brw_cycles), 64'(m_brw));
`else
    check("ldu_cycles", 64'(bus.ldu_cycles), 64'd0);
    check("brw_cycles", 64'(bus.brw_cycles), 64'd0);
`endif
    if (hz && m_mode == 0) m_ldu++;
    if (m_mode == 1) m_brw++;
    rd = int'(bus.de_ir[11:7]);
    if (bus.wb_v && bus.wb_ld_done) m_pend[bus.wb_drid] = 1'b0;
    if (iss && bus.de_ir[6:0] == OP_LW && rd != 0) m_pend[rd] = 1'b1;
    m_to = 0;
    if (m_mode == 0) begin
      if (iss && bus.de_ir[6:0] inside {OP_BEQ, OP_JALR}) begin
        m_mode = 1; m_spent = 0;
      end
    end else if (m_mode == 1) begin
      m_spent++;
      if (bus.br_resolved) m_mode = bus.br_taken ? 2 : 0;
      else if (m_spent == TO_CYC) begin m_mode = 0; m_to = 1; end
    end else begin
      m_mode = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int op_sel;
    logic [6:0] ops [11];
    ops = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1100111, 7'b1110011, 7'b1101111, 7'b0110111};
    idle();
    model_reset();
    reset = 1'b0;
    #12;
    check("rst_state", 64'(bus.state), 64'd0);
    check("rst_fe_flush", 64'(bus.fe_flush), 64'd0);
    check("rst_br_to", 64'(bus.br_to), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // load-use on x5, released one cycle after the WB write
    bus.de_v = 1'b1; bus.de_ir = mk(OP_LW, 5, 1, 0, 3'b010);
    cycle();
    bus.de_ir = mk(OP_ADD, 6, 5, 1, 3'b000); #1;
    check("ldu_stall", 64'(bus.de_stall), 64'd1);
    check("ldu_bubble", 64'(bus.exe_v_in), 64'd0);
    cycle();
    bus.wb_v = 1'b1; bus.wb_ld_done = 1'b1; bus.wb_drid = 5'd5; #1;
    check("wb_no_bypass", 64'(bus.de_stall), 64'd1);
    cycle();
    bus.wb_v = 1'b0; bus.wb_ld_done = 1'b0; #1;
    check("ldu_release", 64'(bus.de_stall), 64'd0);
    check("ldu_issue", 64'(bus.exe_v_in), 64'd1);
    cycle();

    // x0 loads never pend; store rs2 hazard; csr immediate ignores rs1 field
    bus.de_ir = mk(OP_LW, 0, 1, 0, 3'b010); cycle();
    bus.de_ir = mk(OP_ADD, 6, 0, 0, 3'b000); #1;
    check("x0_no_stall", 64'(bus.de_stall), 64'd0);
    cycle();
    bus.de_ir = mk(OP_LW, 7, 1, 0, 3'b010); cycle();
    bus.de_ir = mk(OP_SW, 0, 2, 7, 3'b010); #1;
    check("sw_rs2_stall", 64'(bus.de_stall), 64'd1);
    cycle();
    bus.de_ir = mk(OP_CSR, 1, 7, 0, 3'b101); #1;
    check("csri_no_stall", 64'(bus.de_stall), 64'd0);
    cycle();
    bus.de_v = 1'b0; bus.wb_v = 1'b1; bus.wb_ld_done = 1'b1; bus.wb_drid = 5'd7;
    cycle();
    bus.wb_v = 1'b0; bus.wb_ld_done = 1'b0;

    // taken beq: wait, flush, run
    bus.de_v = 1'b1; bus.de_ir = mk(OP_BEQ, 0, 1, 2, 3'b000); cycle();
    bus.de_ir = mk(OP_ADD, 3, 1, 2, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("brw_state", 64'(bus.state), 64'd1);
      check("brw_stall", 64'(bus.de_stall), 64'd1);
      cycle();
    end
    bus.br_resolved = 1'b1; bus.br_taken = 1'b1; cycle();
    bus.br_resolved = 1'b0; bus.br_taken = 1'b0;
    check("flush_pulse", 64'(bus.fe_flush), 64'd1);
    check("flush_state", 64'(bus.state), 64'd2);
    cycle();
    check("post_flush_state", 64'(bus.state), 64'd0);
    check("post_flush_fe", 64'(bus.fe_flush), 64'd0);

    // jalr never resolved: timeout after TO_CYC wait cycles
    bus.de_ir = mk(OP_JALR, 1, 2, 0, 3'b000); cycle();
    bus.de_v = 1'b0;
    for (int i = 0; i < TO_CYC; i++) begin
      check("to_wait_state", 64'(bus.state), 64'd1);
      check("to_no_pulse", 64'(bus.br_to), 64'd0);
      cycle();
    end
    check("to_pulse", 64'(bus.br_to), 64'd1);
    check("to_state_run", 64'(bus.state), 64'd0);
    cycle();
    check("to_pulse_once", 64'(bus.br_to), 64'd0);

    // set beats clear on same index; mem stall bubbles a clean instruction
    bus.de_v = 1'b1; bus.de_ir = mk(OP_LW, 9, 1, 0, 3'b010);
    bus.wb_v = 1'b1; bus.wb_ld_done = 1'b1; bus.wb_drid = 5'd9; cycle();
    bus.wb_v = 1'b0; bus.wb_ld_done = 1'b0;
    bus.de_ir = mk(OP_ADD, 1, 9, 0, 3'b000); #1;
    check("set_wins", 64'(bus.de_stall), 64'd1);
    cycle();
    bus.de_ir = mk(OP_ADD, 1, 2, 3, 3'b000); bus.mem_stall = 1'b1; #1;
    check("memstall_bubble", 64'(bus.exe_v_in), 64'd0);
    check("memstall_stall", 64'(bus.de_stall), 64'd1);
    cycle();
    bus.mem_stall = 1'b0; bus.de_ir = mk(OP_ADD, 1, 9, 0, 3'b000); #1;
    check("memstall_pend_kept", 64'(bus.de_stall), 64'd1);
    cycle();

    // async reset inside a branch wait with x3 pending
    bus.de_ir = mk(OP_LW, 3, 1, 0, 3'b010); cycle();
    bus.de_ir = mk(OP_BEQ, 0, 1, 2, 3'b000); cycle();
    bus.de_v = 1'b0; cycle();
    reset = 1'b0; #1;
    check("arst_state", 64'(bus.state), 64'd0);
    check("arst_fe_flush", 64'(bus.fe_flush), 64'd0);
    check("arst_ldu", 64'(bus.ldu_cycles), 64'd0);
    check("arst_brw", 64'(bus.brw_cycles), 64'd0);
    model_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("arst_no_flush", 64'(bus.fe_flush), 64'd0);
    bus.de_v = 1'b1; bus.de_ir = mk(OP_ADD, 1, 3, 0, 3'b000); #1;
    check("arst_pend_clear", 64'(bus.de_stall), 64'd0);
    cycle();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      op_sel = int'($urandom_range(0, 10));
      bus.de_v       = ($urandom_range(0, 3) != 0);
      bus.de_ir      = mk(ops[op_sel], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      bus.mem_stall  = ($urandom_range(0, 6) == 0);
      bus.wb_v       = ($urandom_range(0, 2) == 0);
      bus.wb_ld_done = ($urandom_range(0, 1) == 0);
      bus.wb_drid    = 5'($urandom_range(0, 7));
      bus.br_resolved = (m_mode == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) == 0);
      bus.br_taken   = ($urandom_range(0, 1) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_interlock_ctrl.md
Name: decode_interlock_ctrl

Overview:
- Sequences the decode stage: decides each cycle whether the instruction in DE issues to EXE, holds, or becomes a bubble.
- Keeps a 32-entry load-pending scoreboard for load-use hazards that the MEM/WB forwarding paths cannot cover.
- Runs a control-flow FSM that freezes fetch/decode while a branch or JALR is unresolved, and flushes fetch on a taken one.
- Sits beside the decode datapath; drives its LD_AGEX/EXE_V gating and the fetch stall/flush.

Parameters:
BR_TIMEOUT, 16, max cycles in BR_WAIT before forced return to RUN (2..255)
CNT_W, 32, width of optional performance counters

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
DE_V  in  1  DE latch holds a valid instruction
DE_IR  in  32  instruction in DE
MEM_STALL  in  1  memory stage stall
WB_V  in  1  WB stage valid
WB_LD_DONE  in  1  WB is writing load data to the register file
WB_DRID  in  5  WB destination register
BR_RESOLVED  in  1  EXE resolved the outstanding branch/JALR (1-cycle pulse)
BR_TAKEN  in  1  qualifies BR_RESOLVED
DE_STALL  out  1  hold the DE latch and fetch PC
EXE_V_IN  out  1  valid bit to latch into EXE (0 = bubble)
FE_FLUSH  out  1  squash the fetched instruction, redirect PC
BR_TO  out  1  1-cycle pulse: branch-wait timeout
STATE  out  2  FSM state (debug)
LDU_CYCLES  out  CNT_W  load-use stall cycles (optional)
BRW_CYCLES  out  CNT_W  branch-wait cycles (optional)

Behaviour:
- Decode of DE_IR:
  - opc = [6:0], rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - use_rs1 for opc 0110011, 0111011, 0010011, 0011011, 0000011, 0100011, 1100011, 1100111; also for 1110011 when [14] = 0.
  - use_rs2 for opc 0110011, 0111011, 0100011, 1100011.
  - is_ld: opc 0000011 and rd != 0.
  - is_cf: opc 1100011 or 1100111. JAL is not cf.
- Hazard: hazard = DE_V & ((use_rs1 & rs1 != 0 & pend[rs1]) | (use_rs2 & rs2 != 0 & pend[rs2])).
- States: RUN = 0, BR_WAIT = 1, FLUSH = 2. Encoding 3 is illegal and returns to RUN on the next edge.
- issue = DE_V & state == RUN & !hazard & !MEM_STALL.
- Combinational outputs:
  - EXE_V_IN = issue.
  - DE_STALL = MEM_STALL | hazard | (state != RUN).
  - STATE = state.
- Scoreboard (pend, 32 bits, bit 0 hardwired 0):
  - issue & is_ld sets pend[rd] on the next edge.
  - WB_V & WB_LD_DONE clears pend[WB_DRID] on the next edge.
  - Set and clear of the same index in one cycle: set wins.
  - A WB clear in the same cycle as a hazard on that register does not release the stall until the next cycle. There is no combinational bypass.
- FSM:
  - RUN: issue & is_cf -> BR_WAIT, with the timeout counter loaded to 0.
  - BR_WAIT: DE_V is ignored; EXE_V_IN = 0; the counter increments each cycle.
    - BR_RESOLVED & BR_TAKEN -> FLUSH.
    - BR_RESOLVED & !BR_TAKEN -> RUN.
    - Counter reaches BR_TIMEOUT - 1 with no resolve -> RUN, with BR_TO high for 1 cycle.
    - BR_RESOLVED is honoured even while MEM_STALL = 1.
  - FLUSH: FE_FLUSH = 1 for exactly 1 cycle, then RUN. BR_RESOLVED is ignored in FLUSH.
- Registered outputs: FE_FLUSH and BR_TO.
- Reset: async assert clears pend = 0, state = RUN, counter = 0, FE_FLUSH = 0, BR_TO = 0, perf counters = 0. Reset asserted mid-BR_WAIT abandons the wait and sends no flush.
- Latency: hazard to stall is 0 cycles; WB_LD_DONE to stall release is 1 cycle; BR_RESOLVED (taken) to FE_FLUSH is 1 cycle; FLUSH to RUN is 1 cycle.

Optional Feature:
DECODE_INTERLOCK_PERF_EN:
- Defined:
  - LDU_CYCLES increments each cycle with hazard & state == RUN.
  - BRW_CYCLES increments each cycle with state == BR_WAIT.
  - Both saturate at all-ones, both reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Load x5 issues; next cycle DE = add x6,x5,x1 (DE_V = 1) -> DE_STALL = 1, EXE_V_IN = 0. Pulse WB_V = WB_LD_DONE = 1, WB_DRID = 5 -> next cycle DE_STALL = 0, EXE_V_IN = 1.
- Load x0, then use x0 -> pend stays 0, no stall. Store sw x7,0(x2) with pend[7] = 1 -> stall (rs2 use). csrrwi with rs1 field = 7 -> no stall.
- beq issues -> STATE = 1, DE_STALL = 1 for 3 cycles. BR_RESOLVED = 1, BR_TAKEN = 1 -> next cycle FE_FLUSH = 1, STATE = 2. Following cycle STATE = 0, FE_FLUSH = 0.
- jalr issues; BR_RESOLVED never asserted with BR_TIMEOUT = 16 -> after 16 cycles in BR_WAIT, BR_TO pulses once and STATE = 0.
- Same cycle: load x9 issues while WB clears x9 -> pend[9] = 1 afterwards. MEM_STALL = 1 with clean DE -> EXE_V_IN = 0, DE_STALL = 1, scoreboard unchanged.
- reset low during BR_WAIT with pend[3] = 1 -> immediately STATE = 0, pend = 0, FE_FLUSH = 0; with PERF_EN, counters read 0.
